// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: serves hits combinationally,
// stalls the IF stage on a miss while a 16-byte block is fetched and refilled.
module icache_controller #(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic [31:0]          ADDRESS,
    output logic [31:0]          READINST,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic [27:0]          MEM_ADDRESS,
    input  logic [127:0]         MEM_READINST,
    input  logic                 MEM_BUSYWAIT,
    output logic [CNT_WIDTH-1:0] HIT_COUNT,
    output logic [CNT_WIDTH-1:0] MISS_COUNT
);

    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NUM_BLOCKS];
    logic [127:0]          r_data [NUM_BLOCKS];
    logic [27:0]           r_fill_addr;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_hit;
    logic [127:0]          w_line;
    logic [31:0]           w_word;
    logic                  w_start_fill;
    logic                  w_refill;
    logic                  w_count_hit;
    logic                  w_unused;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Byte-within-word bits never matter for a 32-bit instruction fetch.
    assign w_unused     = ^ADDRESS[1:0];

    assign w_offset     = ADDRESS[3:2];
    assign w_index      = ADDRESS[3+INDEX_BITS:4];
    assign w_tag        = ADDRESS[31:4+INDEX_BITS];
    assign w_fill_index = r_fill_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_fill_addr[27:INDEX_BITS];

    assign w_hit  = READ & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_line = r_data[w_index];
    assign w_word = w_line[{w_offset, 5'b0} +: 32];

    assign MEM_ADDRESS = r_fill_addr;
    assign HIT_COUNT   = r_hit_count;
    assign MISS_COUNT  = r_miss_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        BUSYWAIT     = 1'b0;
        MEM_READ     = 1'b0;
        READINST     = 32'h0;
        w_start_fill = 1'b0;
        w_refill     = 1'b0;
        w_count_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (READ) begin
                    if (w_hit) begin
                        READINST    = w_word;
                        w_count_hit = 1'b1;
                    end else begin
                        BUSYWAIT     = 1'b1;
                        w_start_fill = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // The fill always completes against the latched block address.
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    w_refill     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid      <= '0;
            r_fill_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_start_fill) begin
                r_fill_addr  <= ADDRESS[31:4];
                r_miss_count <= sat_inc(r_miss_count);
            end
            if (w_count_hit) begin
                r_hit_count <= sat_inc(r_hit_count);
            end
            if (w_refill) begin
                r_valid[w_fill_index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays are qualified by r_valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (w_refill) begin
            r_data[w_fill_index] <= MEM_READINST;
            r_tag[w_fill_index]  <= w_fill_tag;
        end
    end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped instruction cache controller between the IF stage (PC side) and the block-wide instruction memory.
- Serves hits combinationally in the same cycle.
- On a miss, stalls the pipeline via BUSYWAIT, fetches a 16-byte block from memory, refills the entry, then serves the word.
- Keeps saturating hit/miss counters for performance debug.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two, 2..64.
- INDEX_BITS, 3, log2(NUM_BLOCKS); must match NUM_BLOCKS.
- CNT_WIDTH, 16, width of the hit/miss counters.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- READ  input  1  IF stage requests the instruction at ADDRESS.
- ADDRESS  input  32  byte address (PC); bits[1:0] ignored.
- READINST  output  32  instruction word; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  output  1  stall to IF stage.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address (byte address[31:4]).
- MEM_READINST  input  128  refill block; word0 in [31:0], word3 in [127:96].
- MEM_BUSYWAIT  input  1  memory busy; data valid on the posedge where it is sampled low while MEM_READ=1.
- HIT_COUNT  output  CNT_WIDTH  saturating hit counter.
- MISS_COUNT  output  CNT_WIDTH  saturating miss counter.

Behaviour:
- Address split: word offset = ADDRESS[3:2]; index = ADDRESS[3+INDEX_BITS:4]; tag = ADDRESS[31:4+INDEX_BITS] (25 bits at default).
- Per line storage: valid bit, tag, 4x32 data.
- hit = READ & valid[index] & (tag_array[index]==tag).
- States:
  - IDLE: default state.
  - FETCH: MEM_READ=1; MEM_ADDRESS driven from fill_addr register.
- IDLE:
  - READ & hit: READINST = selected word, same cycle (combinational); BUSYWAIT=0; HIT_COUNT+1 at posedge.
  - READ & miss: BUSYWAIT=1 combinationally. At posedge: fill_addr <= ADDRESS[31:4], MISS_COUNT+1, go to FETCH.
  - READ=0: BUSYWAIT=0, READINST=0.
- FETCH:
  - BUSYWAIT=1 regardless of READ/ADDRESS.
  - Stay while MEM_BUSYWAIT=1.
  - On posedge with MEM_BUSYWAIT=0: write MEM_READINST into data[fill index], tag <= fill tag, valid <= 1; go to IDLE.
  - MEM_READ drops in the cycle after that edge.
- Miss latency: the requested word is served in the IDLE cycle following the refill edge. Total stall = memory busy cycles + 2 cycles.
- Refill targets the latched fill_addr, not the live ADDRESS. If ADDRESS changes mid-fill, the new address is looked up after return to IDLE and may miss again.
- READ deasserted during FETCH: fill still completes, no abort; BUSYWAIT stays 1 until IDLE.
- READINST when not hit: 32'h0.
- Counters: saturate at all-ones, no wrap. A hit is counted per cycle per served word; a miss is counted once per refill.
- Refill to a valid line overwrites it with no write-back (instruction side is read-only).
- RESET asserted (asynchronous, any state, including mid-FETCH):
  - Immediately: state=IDLE, all valid=0, MEM_READ=0, MEM_ADDRESS=0, fill_addr=0, HIT_COUNT=0, MISS_COUNT=0.
  - Any in-flight refill is discarded; no array write.
  - Data and tag arrays need not be cleared.
- After RESET release: the first READ to any address misses.
- No self-loop on memory errors: MEM_BUSYWAIT held high keeps FETCH indefinitely.

Test Plan:
- Reset then READ=1, ADDRESS=0x00; memory busy 5 cycles.
  - Required: BUSYWAIT=1 in the same cycle; MEM_READ=1 with MEM_ADDRESS=0x0000000.
  - Required: after refill, READINST = word0 and BUSYWAIT=0 (7 stall cycles); MISS_COUNT=1.
- After the previous scenario, ADDRESS 0x04, 0x08, 0x0C on consecutive cycles.
  - Required: each served the same cycle with BUSYWAIT=0; HIT_COUNT=3; MEM_READ stays 0.
- Conflict: ADDRESS=0x80 (same index 0, different tag).
  - Required: miss, refill overwrites line 0, MEM_ADDRESS=0x0000008.
  - Required: a subsequent read of 0x00 misses again; MISS_COUNT increments per miss.
- ADDRESS changes from 0x10 to 0x24 while in FETCH.
  - Required: refill writes the block at 0x10 (MEM_ADDRESS held at 0x0000001).
  - Required: a second miss follows for 0x24 with MEM_ADDRESS=0x0000002.
- RESET pulsed mid-FETCH (memory busy 10 cycles, reset at cycle 4).
  - Required: MEM_READ=0 and BUSYWAIT=0 immediately (READ=0).
  - Required: re-reading 0x00 misses; line not marked valid.
- Force HIT_COUNT near saturation (CNT_WIDTH=4 build), 20 hits.
  - Required: HIT_COUNT stops at 4'hF; MISS_COUNT unaffected.
